// File: rtl/hand_zone_pkg.sv
// Shared constants, state and result types for the hand-signal zone scan controller.
// Build option ZONE_HOLD_EN (see zone_scan_ctrl) changes how a not-found zone is reported.
package hand_zone_pkg;

  localparam int NX        = 8;
  localparam int NY        = 6;
  localparam int ZONES     = NX * NY;
  localparam int ZBW       = $clog2(ZONES);
  localparam int CNT_W     = 16;
  localparam int MIN_COUNT = 64;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } scan_state_t;

  typedef struct packed {
    logic [ZBW-1:0]   zone;
    logic [CNT_W-1:0] count;
    logic             found;
  } zone_result_t;

  // A zone is only reported when its count clears the threshold; otherwise miss_zone is shown.
  function automatic zone_result_t make_result(input logic [ZBW-1:0]   max_zone,
                                               input logic [CNT_W-1:0] max_count,
                                               input logic [ZBW-1:0]   miss_zone);
    zone_result_t r;
    r.count = max_count;
    r.found = (max_count >= CNT_W'(MIN_COUNT));
    r.zone  = r.found ? max_zone : miss_zone;
    return r;
  endfunction

endpackage

// File: rtl/zone_scan_ctrl_if.sv
// Pixel-hit inputs and result handshake of the zone scan controller.
interface zone_scan_ctrl_if;
  import hand_zone_pkg::*;

  logic             frame_end;
  logic             blue_hit;
  logic             red_hit;
  logic [ZBW-1:0]   zone_id;
  logic             res_valid;
  logic             res_ready;
  logic [ZBW-1:0]   blue_zone;
  logic [ZBW-1:0]   red_zone;
  logic             blue_found;
  logic             red_found;
  logic [CNT_W-1:0] blue_count;
  logic [CNT_W-1:0] red_count;
  logic             busy;
  logic             overrun;

  modport master (
    output frame_end, blue_hit, red_hit, zone_id, res_ready,
    input  res_valid, blue_zone, red_zone, blue_found, red_found,
           blue_count, red_count, busy, overrun
  );

  modport slave (
    input  frame_end, blue_hit, red_hit, zone_id, res_ready,
    output res_valid, blue_zone, red_zone, blue_found, red_found,
           blue_count, red_count, busy, overrun
  );

endinterface

// File: rtl/zone_count_bank.sv
// One colour's bank of saturating per-zone hit counters with scan read/clear port.
module zone_count_bank
  import hand_zone_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en,
  input  logic [ZBW-1:0]   inc_idx,
  input  logic             clr_en,
  input  logic             clr_all,
  input  logic [ZBW-1:0]   rd_idx,
  output logic [CNT_W-1:0] rd_data
);

  logic [CNT_W-1:0] cnt [ZONES];

  // The read index doubles as the clear index so the scan wipes each entry it consumes;
  // indices past the last zone match no entry and are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ZONES; i++) cnt[i] <= '0;
    end else if (clr_all) begin
      for (int i = 0; i < ZONES; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < ZONES; i++) begin
        if (clr_en && rd_idx == ZBW'(i))
          cnt[i] <= '0;
        else if (inc_en && inc_idx == ZBW'(i) && cnt[i] != '1)
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign rd_data = (rd_idx < ZBW'(ZONES)) ? cnt[rd_idx] : '0;

endmodule

// File: rtl/zone_scan_ctrl.sv
// Per-frame ping-pong zone hit counting with a max-zone scan per colour.
// Define ZONE_HOLD_EN to keep the last found zone on the outputs when a colour is missing.
module zone_scan_ctrl
  import hand_zone_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  zone_scan_ctrl_if.slave bus
);

  scan_state_t      state, state_next;
  logic             bank_sel;
  logic [ZBW-1:0]   scan_idx;
  logic [CNT_W-1:0] blue_max, red_max;
  logic [ZBW-1:0]   blue_max_zone, red_max_zone;
  zone_result_t     blue_res, red_res;
  logic             overrun_q;

  logic             frame_start, frame_drop, scan_last;
  logic [CNT_W-1:0] blue_rd [2];
  logic [CNT_W-1:0] red_rd [2];
  logic [CNT_W-1:0] blue_cur, red_cur;
  logic [CNT_W-1:0] blue_max_nx, red_max_nx;
  logic [ZBW-1:0]   blue_zone_nx, red_zone_nx;
  logic [ZBW-1:0]   blue_miss, red_miss;

  assign frame_start = (state == IDLE) && bus.frame_end;
  assign frame_drop  = (state != IDLE) && bus.frame_end;
  assign scan_last   = (scan_idx == ZBW'(ZONES - 1));

  // Hits always land in the active bank; the closed bank is only read and cleared by the scan.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    zone_count_bank u_blue (
      .clk     (clk),
      .reset   (reset),
      .inc_en  (bus.blue_hit && bank_sel == 1'(b)),
      .inc_idx (bus.zone_id),
      .clr_en  (state == SCAN && bank_sel != 1'(b)),
      .clr_all (frame_drop && bank_sel == 1'(b)),
      .rd_idx  (scan_idx),
      .rd_data (blue_rd[b])
    );
    zone_count_bank u_red (
      .clk     (clk),
      .reset   (reset),
      .inc_en  (bus.red_hit && bank_sel == 1'(b)),
      .inc_idx (bus.zone_id),
      .clr_en  (state == SCAN && bank_sel != 1'(b)),
      .clr_all (frame_drop && bank_sel == 1'(b)),
      .rd_idx  (scan_idx),
      .rd_data (red_rd[b])
    );
  end

  assign blue_cur = bank_sel ? blue_rd[0] : blue_rd[1];
  assign red_cur  = bank_sel ? red_rd[0]  : red_rd[1];

  // Strict greater-than keeps the lowest index on ties.
  assign blue_max_nx  = (blue_cur > blue_max) ? blue_cur : blue_max;
  assign blue_zone_nx = (blue_cur > blue_max) ? scan_idx : blue_max_zone;
  assign red_max_nx   = (red_cur > red_max) ? red_cur : red_max;
  assign red_zone_nx  = (red_cur > red_max) ? scan_idx : red_max_zone;

`ifdef ZONE_HOLD_EN
  assign blue_miss = blue_res.zone;
  assign red_miss  = red_res.zone;
`else
  assign blue_miss = '0;
  assign red_miss  = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.frame_end) state_next = SCAN;
      SCAN:    if (scan_last)     state_next = HOLD;
      HOLD:    if (bus.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_sel      <= 1'b0;
      scan_idx      <= '0;
      blue_max      <= '0;
      red_max       <= '0;
      blue_max_zone <= '0;
      red_max_zone  <= '0;
      blue_res      <= '0;
      red_res       <= '0;
      overrun_q     <= 1'b0;
    end else begin
      overrun_q <= frame_drop;
      if (frame_start) begin
        bank_sel      <= ~bank_sel;
        scan_idx      <= '0;
        blue_max      <= '0;
        red_max       <= '0;
        blue_max_zone <= '0;
        red_max_zone  <= '0;
      end else if (state == SCAN) begin
        scan_idx      <= scan_last ? '0 : scan_idx + 1'b1;
        blue_max      <= blue_max_nx;
        red_max       <= red_max_nx;
        blue_max_zone <= blue_zone_nx;
        red_max_zone  <= red_zone_nx;
        if (scan_last) begin
          blue_res <= make_result(blue_zone_nx, blue_max_nx, blue_miss);
          red_res  <= make_result(red_zone_nx, red_max_nx, red_miss);
        end
      end
    end
  end

  assign bus.res_valid  = (state == HOLD);
  assign bus.busy       = (state != IDLE);
  assign bus.overrun    = overrun_q;
  assign bus.blue_zone  = blue_res.zone;
  assign bus.blue_count = blue_res.count;
  assign bus.blue_found = blue_res.found;
  assign bus.red_zone   = red_res.zone;
  assign bus.red_count  = red_res.count;
  assign bus.red_found  = red_res.found;

endmodule
